// File: rtl/qc_ldpc_syndrome_former_pkg.sv
// Shared QC-LDPC code parameters and FSM state encoding, common to the encoder and the syndrome former.
package qc_ldpc_syndrome_former_pkg;

  localparam int unsigned Z_DEF  = 16;
  localparam int unsigned MB_DEF = 2;
  localparam int unsigned NB_DEF = 4;

  // H = [I I I I; I I I I]: every circulant is the identity.
  localparam logic [MB_DEF*NB_DEF*Z_DEF-1:0] H_COLS_DEF = {MB_DEF*NB_DEF{16'h0001}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/qc_circulant_column_gen.sv
// Rotating Z-bit register producing successive columns of one circulant; load selects a new first column.
module qc_circulant_column_gen #(
  parameter int unsigned Z = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [Z-1:0] load_col,
  output logic [Z-1:0] col
);

  // Load wins over rotation; rotation moves every bit one place toward the MSB.
  always_ff @(posedge clk) begin
    if (load) begin
      col <= load_col;
    end else if (shift) begin
      col <= {col[Z-2:0], col[Z-1]};
    end
  end

endmodule

// File: rtl/qc_ldpc_syndrome_former.sv
// Bit-serial QC-LDPC syndrome former: accumulates s = H*c over GF(2) and reports syndrome, zero flag and weight.
module qc_ldpc_syndrome_former
  import qc_ldpc_syndrome_former_pkg::*;
#(
  parameter int unsigned         Z      = Z_DEF,
  parameter int unsigned         MB     = MB_DEF,
  parameter int unsigned         NB     = NB_DEF,
  parameter logic [MB*NB*Z-1:0]  H_COLS = (MB*NB*Z)'(H_COLS_DEF)
) (
  input  logic                        clk,
  input  logic                        clear_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_bit,
  output logic                        syn_valid,
  input  logic                        syn_ready,
  output logic [MB*Z-1:0]             syndrome,
  output logic                        syn_zero,
  output logic [$clog2(MB*Z+1)-1:0]   syn_weight
);

  localparam int unsigned SW = MB * Z;
  localparam int unsigned BW = (Z > 1) ? $clog2(Z) : 1;
  localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WW = $clog2(SW + 1);

  state_t          state;
  logic [BW-1:0]   bit_idx;
  logic [KW-1:0]   blk_idx;
  logic [SW-1:0]   acc;
  logic [SW-1:0]   gen;
  logic [SW-1:0]   acc_next_c;
  logic [WW-1:0]   weight_next_c;
  logic [KW-1:0]   blk_next_c;
  logic [KW-1:0]   load_sel_c;
  logic            xfer_c;
  logic            last_bit_c;
  logic            last_blk_c;
  logic            restart_c;
  logic            gen_load_c;

  assign xfer_c     = in_valid & in_ready;
  assign last_bit_c = (bit_idx == BW'(Z - 1));
  assign last_blk_c = (blk_idx == KW'(NB - 1));
  assign restart_c  = (state == HOLD) & syn_ready;
  assign blk_next_c = last_blk_c ? '0 : KW'(blk_idx + KW'(1));

  // Column generators restart at block 0 on clear or frame release, else step to the next block.
  assign load_sel_c = (!clear_n || restart_c) ? '0 : blk_next_c;
  assign gen_load_c = !clear_n || restart_c || (xfer_c && last_bit_c);

  for (genvar m = 0; m < MB; m++) begin : g_row
    logic [Z-1:0] first_col_c;
    assign first_col_c = H_COLS[(m*NB + 32'(load_sel_c))*Z +: Z];

    qc_circulant_column_gen #(.Z(Z)) u_col_gen (
      .clk      (clk),
      .load     (gen_load_c),
      .shift    (xfer_c),
      .load_col (first_col_c),
      .col      (gen[m*Z +: Z])
    );
  end

  assign acc_next_c = acc ^ (gen & {SW{in_bit}});

  always_comb begin
    weight_next_c = '0;
    for (int i = 0; i < SW; i++) begin
      weight_next_c = weight_next_c + WW'(acc_next_c[i]);
    end
  end

  // Control FSM, counters, accumulators and registered result.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state      <= ACCUM;
      bit_idx    <= '0;
      blk_idx    <= '0;
      acc        <= '0;
      in_ready   <= 1'b1;
      syn_valid  <= 1'b0;
      syndrome   <= '0;
      syn_zero   <= 1'b1;
      syn_weight <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (xfer_c) begin
            acc     <= acc_next_c;
            bit_idx <= last_bit_c ? '0 : BW'(bit_idx + BW'(1));
            if (last_bit_c) begin
              blk_idx <= blk_next_c;
            end
            if (last_bit_c && last_blk_c) begin
              state      <= HOLD;
              in_ready   <= 1'b0;
              syn_valid  <= 1'b1;
              syndrome   <= acc_next_c;
              syn_zero   <= (acc_next_c == '0);
              syn_weight <= weight_next_c;
            end
          end
        end
        HOLD: begin
          if (syn_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            syn_valid <= 1'b0;
            acc       <= '0;
            bit_idx   <= '0;
            blk_idx   <= '0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qc_ldpc_syndrome_former.sv
// Self-checking bench: two instances (default H and H(0,0)=0x0005) share stimulus and are checked against a GF(2) model.
module tb_qc_ldpc_syndrome_former;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_bit;
  logic        syn_ready;
  logic        in_ready, in_ready5;
  logic        syn_valid, syn_valid5;
  logic [31:0] syndrome, syndrome5;
  logic        syn_zero, syn_zero5;
  logic [5:0]  syn_weight, syn_weight5;

  int tests = 0;
  int fails = 0;

  logic [127:0] h_def;
  logic [127:0] h_five;

  always #5 clk = ~clk;

  qc_ldpc_syndrome_former dut (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syndrome(syndrome), .syn_zero(syn_zero),
    .syn_weight(syn_weight)
  );

  qc_ldpc_syndrome_former #(.H_COLS({{7{16'h0001}}, 16'h0005})) dut5 (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready5), .in_bit(in_bit),
    .syn_valid(syn_valid5), .syn_ready(syn_ready), .syndrome(syndrome5), .syn_zero(syn_zero5),
    .syn_weight(syn_weight5)
  );

  // s = H*c: column j of circulant (m,b) is its first column rotated j places toward the MSB.
  function automatic logic [31:0] model(input logic [63:0] cw, input logic [127:0] h);
    logic [31:0] s = '0;
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 4; b++)
        for (int j = 0; j < 16; j++)
          if (cw[b*16 + j])
            for (int r = 0; r < 16; r++)
              if (h[(m*4 + b)*16 + ((r - j + 16) % 16)]) s[m*16 + r] = ~s[m*16 + r];
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; syn_ready = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
    chk({tag, "_syn_valid"}, 64'(syn_valid),  64'd0);
    chk({tag, "_syndrome"},  64'(syndrome),   64'd0);
    chk({tag, "_syn_zero"},  64'(syn_zero),   64'd1);
    chk({tag, "_weight"},    64'(syn_weight), 64'd0);
    chk({tag, "_syndrome5"}, 64'(syndrome5),  64'd0);
  endtask

  // Send the first nbits of cw with random in_valid gaps; returns on a negedge after the last transfer.
  task automatic run_frame(input logic [63:0] cw, input int gap_pct, input int nbits);
    int  i = 0;
    int  cyc = 0;
    bit  rdy, v;
    while (i < nbits) begin
      @(negedge clk);
      rdy = in_ready;
      v = ($urandom_range(99) >= 32'(gap_pct));
      in_valid  = v;
      in_bit    = v ? cw[i] : 1'($urandom);
      syn_ready = 1'($urandom);
      @(posedge clk);
      if (v && rdy) i++;
      cyc++;
      if (cyc > 4000) begin
        tests++; fails++;
        $display("FAIL frame_timeout: got %0d bits expected %0d", i, nbits);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; syn_ready = 1'b0;
  endtask

  // Check the result one cycle after the last bit, hold it, then release it.
  task automatic chk_result(input string name, input logic [31:0] exp, input logic [31:0] exp5, input int hold);
    chk({name, "_valid"},     64'(syn_valid),   64'd1);
    chk({name, "_valid5"},    64'(syn_valid5),  64'd1);
    chk({name, "_in_ready"},  64'(in_ready),    64'd0);
    chk({name, "_syndrome"},  64'(syndrome),    64'(exp));
    chk({name, "_zero"},      64'(syn_zero),    64'(exp == 32'd0));
    chk({name, "_weight"},    64'(syn_weight),  64'($countones(exp)));
    chk({name, "_syndrome5"}, 64'(syndrome5),   64'(exp5));
    chk({name, "_weight5"},   64'(syn_weight5), 64'($countones(exp5)));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_bit = 1'($urandom); syn_ready = 1'b0;
      @(negedge clk);
      chk({name, "_hold_valid"},    64'(syn_valid), 64'd1);
      chk({name, "_hold_in_ready"}, 64'(in_ready),  64'd0);
      chk({name, "_hold_syndrome"}, 64'(syndrome),  64'(exp));
      chk({name, "_hold_weight"},   64'(syn_weight), 64'($countones(exp)));
    end
    syn_ready = 1'b1;
    @(negedge clk);
    syn_ready = 1'b0; in_valid = 1'b0;
    chk({name, "_rel_valid"},    64'(syn_valid), 64'd0);
    chk({name, "_rel_in_ready"}, 64'(in_ready),  64'd1);
    chk({name, "_rel_syndrome"}, 64'(syndrome),  64'(exp));
  endtask

  typedef struct {
    string       name;
    logic [63:0] cw;
    logic [31:0] exp;
    logic [31:0] exp5;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] cw;
    clear_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; syn_ready = 1'b0;
    h_def  = {8{16'h0001}};
    h_five = {{7{16'h0001}}, 16'h0005};

    vecs[0] = '{"all_zero",     64'h0000_0000_0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{"blk2_bit5",    64'h0000_0020_0000_0000, 32'h0020_0020, 32'h0020_0020};
    vecs[2] = '{"a5a5_pair",    64'h0000_0000_A5A5_A5A5, 32'h0000_0000, 32'h0000_9696};
    vecs[3] = '{"a5a5_blk3",    64'h0001_0000_A5A5_A5A5, 32'h0001_0001, 32'h0001_9697};
    vecs[4] = '{"blk0_bit15",   64'h0000_0000_0000_8000, 32'h8000_8000, 32'h8000_8002};

    do_clear();
    chk_reset_state("reset");

    foreach (vecs[i]) begin
      run_frame(vecs[i].cw, 0, 64);
      chk_result(vecs[i].name, vecs[i].exp, vecs[i].exp5, 2);
    end

    // Gappy input and a consumer that stalls for 10 cycles.
    for (int f = 0; f < 2; f++) begin
      cw = {$urandom, $urandom};
      run_frame(cw, 40, 64);
      chk_result("stall", model(cw, h_def), model(cw, h_five), 10);
    end

    for (int f = 0; f < 6; f++) begin
      cw = {$urandom, $urandom};
      if (f == 0) cw[15:0] = 16'h0000;
      run_frame(cw, 25, 64);
      chk_result("random", model(cw, h_def), model(cw, h_five), int'($urandom_range(3)));
    end

    // Clear after 30 bits discards the partial frame.
    cw = {$urandom, $urandom} | 64'h1;
    run_frame(cw, 0, 30);
    do_clear();
    chk_reset_state("midclear");
    run_frame(64'd0, 10, 64);
    chk_result("after_clear", 32'd0, 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
